// File: rtl/transmit_response.sv
// rtl/transmit_response.sv - Frames a captured payload as ADDR followed by
// NUM_BYTES bytes, MSB first, over a valid/ready byte stream.
module transmit_response #(
  parameter logic [7:0] ADDR      = 8'h00,
  parameter int         NUM_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [8*NUM_BYTES-1:0] i_data,
  input  logic                   i_ready_write,
  output logic [7:0]             o_Byte,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int              DW   = 8 * NUM_BYTES;
  localparam int              CW   = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0]   LAST = CW'(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      byte_d;
  logic            valid_d;
  logic            busy_d;
  logic            done_d;
  logic            xfer;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      o_Byte  <= 8'h00;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      o_Byte  <= byte_d;
      o_valid <= valid_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  // count_q holds the number of bytes already accepted; ADDR is byte zero,
  // so the last payload byte goes out while count_q == NUM_BYTES.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    byte_d  = o_Byte;
    valid_d = o_valid;
    busy_d  = o_busy;
    done_d  = 1'b0;
    xfer    = o_valid && i_ready_write;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          shift_d = i_data;
          byte_d  = ADDR;
          count_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (count_q == LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            byte_d  = shift_q[DW-1 -: 8];
            shift_d = shift_q << 8;
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
